// File: rtl/level_shaper.sv
// Level shaper: forwards requested output levels while guaranteeing that
// every level on SignalOut is held for at least DWELL clock cycles.
module level_shaper #(
    parameter int   DWELL      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       ClkIn,
    input  logic       RstNIn,
    input  logic       LevelIn,
    input  logic       LevelValid,
    output logic       LevelReady,
    output logic       SignalOut,
    output logic       Busy,
    output logic [7:0] Changes
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

    typedef enum logic {
        STABLE,
        HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          pendValid;
    logic          pendLevel;
    logic          accept;

    assign LevelReady = ~pendValid;
    assign accept     = LevelValid & ~pendValid;
    assign Busy       = (state == HOLD);

    always_ff @(posedge ClkIn or negedge RstNIn) begin
        if (!RstNIn) begin
            state     <= STABLE;
            count     <= '0;
            pendValid <= 1'b0;
            pendLevel <= IDLE_LEVEL;
            SignalOut <= IDLE_LEVEL;
            Changes   <= 8'd0;
        end else begin
            unique case (state)
                STABLE: begin
                    if (accept && (LevelIn != SignalOut)) begin
                        SignalOut <= LevelIn;
                        state     <= HOLD;
                        count     <= RELOAD;
                        Changes   <= Changes + 8'd1;
                    end
                end
                HOLD: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                        if (accept) begin
                            pendValid <= 1'b1;
                            pendLevel <= LevelIn;
                        end
                    end else if (pendValid) begin
                        pendValid <= 1'b0;
                        if (pendLevel != SignalOut) begin
                            SignalOut <= pendLevel;
                            count     <= RELOAD;
                            Changes   <= Changes + 8'd1;
                        end else begin
                            state <= STABLE;
                        end
                    end else if (accept && (LevelIn != SignalOut)) begin
                        // dwell just expired: take the new level this edge
                        SignalOut <= LevelIn;
                        count     <= RELOAD;
                        Changes   <= Changes + 8'd1;
                    end else begin
                        state <= STABLE;
                    end
                end
                default: state <= STABLE;
            endcase
        end
    end

endmodule

// File: doc/level_shaper.md
LEVEL_SHAPER -- requirements
Module: level_shaper

Interface
REQ-001 The block SHALL have parameter DWELL, default 8, meaning the minimum number of ClkIn cycles SignalOut holds each level after a change (legal range 2..255).
REQ-002 The block SHALL have parameter IDLE_LEVEL, default 1'b0, meaning the SignalOut level at and after reset.
REQ-003 The block SHALL have port ClkIn  input  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port RstNIn  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port LevelIn  input  1  requested output level.
REQ-006 The block SHALL have port LevelValid  input  1  request strobe; a request transfers on a cycle with LevelValid=1 and LevelReady=1.
REQ-007 The block SHALL have port LevelReady  output  1  high when the one-entry pending slot is empty.
REQ-008 The block SHALL have port SignalOut  output  1  shaped output line, registered.
REQ-009 The block SHALL have port Busy  output  1  high while in state HOLD.
REQ-010 The block SHALL have port Changes  output  8  count of SignalOut transitions since reset, wrapping 255->0.

Function
REQ-011 The block SHALL implement two states: STABLE (dwell satisfied) and HOLD (dwell counter running).
REQ-012 The block SHALL keep a one-entry pending slot (PendValid, PendLevel); LevelReady SHALL equal ~PendValid, combinationally.
REQ-013 In STABLE, an accepted request with LevelIn != SignalOut SHALL update SignalOut to LevelIn on the next edge, enter HOLD, load the counter with DWELL-1, and increment Changes.
REQ-014 In STABLE, an accepted request with LevelIn == SignalOut SHALL be consumed with no change to SignalOut, state, counter or Changes.
REQ-015 In HOLD with counter != 0, the counter SHALL decrement by 1 per cycle, and an accepted request SHALL be written to the pending slot.
REQ-016 In HOLD with counter == 0 and PendValid=1, the next edge SHALL clear PendValid; if PendLevel != SignalOut it SHALL toggle SignalOut, reload DWELL-1, stay in HOLD and increment Changes; otherwise it SHALL enter STABLE.
REQ-017 In HOLD with counter == 0 and PendValid=0, an accepted request SHALL be handled as in STABLE (REQ-013/014) on the same edge, with no extra cycle and no pending write; without a request the block SHALL enter STABLE.
REQ-018 Every SignalOut level SHALL be held for at least DWELL consecutive cycles; a change accepted in STABLE at edge t SHALL appear at t+1, and the earliest following change SHALL appear at t+1+DWELL.
REQ-019 With PendValid=1, LevelValid SHALL be ignored; the requester SHALL hold LevelIn stable until it is accepted.
REQ-020 The counter SHALL be $clog2(DWELL) bits wide and SHALL never wrap below 0.
REQ-021 Busy SHALL be 1 exactly in HOLD, including the cycle in which the counter == 0.

Reset
REQ-022 While RstNIn=0 the block SHALL immediately force SignalOut=IDLE_LEVEL, state=STABLE, counter=0, PendValid=0, PendLevel=IDLE_LEVEL, Changes=0, so LevelReady=1 and Busy=0.
REQ-023 Reset asserted mid-HOLD SHALL discard the pending request and the remaining dwell; the first request after release SHALL be handled as in STABLE.
REQ-024 Reset release SHALL be synchronous to ClkIn, with the first request accepted on the first edge after RstNIn rises.

Verification (DWELL=4, IDLE_LEVEL=0)
REQ-025 Reset, then one request LevelIn=1 at edge 0 -> SignalOut=1 from edge 1, Busy=1 for edges 1..4, STABLE at edge 5, Changes=1.
REQ-026 Request 1 at edge 0, then request 0 at edge 2 -> 0 is accepted into pending (LevelReady drops at edge 3), SignalOut=0 at edge 5, Changes=2, LevelReady=1 at edge 5.
REQ-027 Request 1 at edge 0, then request 1 again at edge 2 -> pending consumed at edge 5 with no toggle, STABLE at edge 5, Changes=1.
REQ-028 Requests 1, 0, 1 presented back to back with LevelValid held -> SignalOut changes at edges 1, 5, 9; no level is shorter than 4 cycles; LevelReady stalls the third request.
REQ-029 Request 1 at edge 0, RstNIn low at edge 2 with 0 pending -> SignalOut=0 immediately, Changes=0, no change after release.
REQ-030 256 alternating requests -> Changes wraps to 0, and every measured level width is >= 4.
